// File: rtl/md_pkg.sv
// ============================================================================
// Module  : md_pkg
// Purpose : Shared op codes, FSM states and counter width for the md sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_cycle_counter.sv
// ============================================================================
// Module  : md_cycle_counter
// Purpose : Loadable down-counter; done_o flags the last busy cycle (count==1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_cycle_counter
    import md_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_i,
    input  logic [MD_CNT_W-1:0] load_val_i,
    input  logic                dec_i,
    input  logic                clear_i,
    output logic                done_o
);

    logic [MD_CNT_W-1:0] count_q;
    logic [MD_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (clear_i) begin
            count_d = '0;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == MD_CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module  : md_sequencer
// Purpose : Multi-cycle MULT/DIV sequencer owning HI/LO; define MD_ABORT_EN
//           to let abort cancel an in-flight op.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MD_CNT_W-1:0] C_MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] C_DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    md_state_e   state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic                cnt_load;
    logic [MD_CNT_W-1:0] cnt_load_val;
    logic                cnt_clear;
    logic                cnt_done;
    logic                abort_w;

`ifdef MD_ABORT_EN
    assign abort_w = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_w      = 1'b0;
`endif

    // Arithmetic; divisors are forced nonzero so b==0 never yields X.
    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, den_s, den_u;
    logic [31:0] sq_mag, sr_mag, quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign mag_a  = a[31] ? (~a + 32'd1) : a;
    assign mag_b  = b[31] ? (~b + 32'd1) : b;
    assign den_s  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign sq_mag = mag_a / den_s;
    assign sr_mag = mag_a % den_s;
    assign quo_s  = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign rem_s  = a[31] ? (~sr_mag + 32'd1) : sr_mag;

    assign den_u  = (b == 32'd0) ? 32'd1 : b;
    assign quo_u  = a / den_u;
    assign rem_u  = a % den_u;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        pend_we_d    = pend_we_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = (op == MD_MULT) ? prod_s : prod_u;
                            pend_we_d    = 1'b1;
                            cnt_load     = 1'b1;
                            cnt_load_val = C_MULT_LOAD;
                            state_d      = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_lo_d    = (op == MD_DIV) ? quo_s : quo_u;
                            pend_hi_d    = (op == MD_DIV) ? rem_s : rem_u;
                            // Divide by zero still takes full latency but leaves HI/LO alone.
                            pend_we_d    = (b != 32'd0);
                            cnt_load     = 1'b1;
                            cnt_load_val = C_DIV_LOAD;
                            state_d      = ST_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (abort_w) begin
                    cnt_clear = 1'b1;
                    pend_we_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (cnt_done) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_we_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    md_cycle_counter u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (state_q == ST_RUN),
        .clear_i    (cnt_clear),
        .done_o     (cnt_done)
    );

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
// Module  : tb_md_sequencer
// Purpose : Self-checking bench for md_sequencer against a cycle-count model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_sequencer;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        abort;
    logic        busy;
    logic [31:0] hi, lo;

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: remaining busy cycles and the result awaiting commit.
    int          m_left;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pvalid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pvalid = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] av,
                              input logic [31:0] bv, input logic ab);
        longint      sa, sb, q, r;
        logic [63:0] p;
        if (m_left > 0) begin
`ifdef MD_ABORT_EN
            if (ab) begin
                m_left = 0;
                m_pvalid = 1'b0;
                return;
            end
`endif
            m_left--;
            if (m_left == 0 && m_pvalid) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s) begin
            case (o)
                MD_MULT: begin
                    p = 64'(longint'($signed(av)) * longint'($signed(bv)));
                    {m_phi, m_plo} = p; m_pvalid = 1'b1; m_left = MULT_N;
                end
                MD_MULTU: begin
                    p = {32'd0, av} * {32'd0, bv};
                    {m_phi, m_plo} = p; m_pvalid = 1'b1; m_left = MULT_N;
                end
                MD_DIV, MD_DIVU: begin
                    sa = (o == MD_DIV) ? longint'($signed(av)) : longint'({32'd0, av});
                    sb = (o == MD_DIV) ? longint'($signed(bv)) : longint'({32'd0, bv});
                    m_left = DIV_N;
                    m_pvalid = (bv != 0);
                    if (bv != 0) begin
                        q = sa / sb;
                        r = sa % sb;
                        m_plo = q[31:0];
                        m_phi = r[31:0];
                    end
                end
                MD_MTHI: m_hi = av;
                MD_MTLO: m_lo = av;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
    endtask

    task automatic cycle(input logic s, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic ab);
        start = s; op = o; a = av; b = bv; abort = ab;
        @(posedge clk);
        model_edge(s, o, av, bv, ab);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; abort = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_outputs();
        @(negedge clk) reset_n = 1'b1;

        // MULT 3 * -2
        cycle(1'b1, MD_MULT, 32'd3, 32'hFFFF_FFFE, 1'b0);
        idle(MULT_N);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFFA);

        cycle(1'b1, MD_DIVU, 32'd7, 32'd2, 1'b0);
        idle(DIV_N);
        chk("divu_lo", {32'd0, lo}, 64'd3);
        chk("divu_hi", {32'd0, hi}, 64'd1);

        cycle(1'b1, MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV_N);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

        cycle(1'b1, MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi", {32'd0, hi}, 64'h1234_5678);

        // MTLO while a MULT is in flight must be dropped
        cycle(1'b1, MD_MULTU, 32'd10, 32'd10, 1'b0);
        cycle(1'b1, MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
        idle(MULT_N);
        chk("mtlo_run", {32'd0, lo}, 64'd100);

        cycle(1'b1, MD_MTHI, 32'hA, 32'd0, 1'b0);
        cycle(1'b1, MD_MTLO, 32'hB, 32'd0, 1'b0);
        cycle(1'b1, MD_DIV, 32'd55, 32'd0, 1'b0);
        idle(DIV_N);
        chk("div0_hi", {32'd0, hi}, 64'hA);
        chk("div0_lo", {32'd0, lo}, 64'hB);

        cycle(1'b1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_N);
        chk("ovf_lo", {32'd0, lo}, 64'h8000_0000);
        chk("ovf_hi", {32'd0, hi}, 64'h0);

        // Asynchronous reset at busy cycle 3
        cycle(1'b1, MD_MULT, 32'd6, 32'd7, 1'b0);
        idle(2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk) reset_n = 1'b1;
        cycle(1'b1, MD_MULT, 32'd6, 32'd7, 1'b0);
        idle(MULT_N);
        chk("post_rst_lo", {32'd0, lo}, 64'd42);

        // Abort at busy cycle 2
        cycle(1'b1, MD_MTHI, 32'd1, 32'd0, 1'b0);
        cycle(1'b1, MD_MTLO, 32'd1, 32'd0, 1'b0);
        cycle(1'b1, MD_MULT, 32'd2, 32'd2, 1'b0);
        idle(1);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
`ifdef MD_ABORT_EN
        chk("abort_busy", {63'd0, busy}, 64'd0);
`endif
        idle(MULT_N);
`ifdef MD_ABORT_EN
        chk("abort_lo", {32'd0, lo}, 64'd1);
`else
        chk("abort_lo", {32'd0, lo}, 64'd4);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            cycle(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), ra, rb,
                  ($urandom_range(0, 15) == 0));
        end
        idle(DIV_N + 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
